// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory access sequencer:
// sizes, RAM direction, FSM states, byte-count and alignment helpers.
package mem_seq_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ISSUE = 3'b001,
    WAIT  = 3'b010,
    DONE  = 3'b011,
    ERR   = 3'b100
  } state_t;

  // index of the last byte of an access (nbytes - 1)
  function automatic logic [1:0] last_idx(
    input logic [1:0] sz
  );
    case (sz)
      SZ_WORD: last_idx = 2'd3;
      SZ_HALF: last_idx = 2'd1;
      default: last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic bad_access(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    case (sz)
      SZ_BYTE: bad_access = 1'b0;
      SZ_HALF: bad_access = a[0];
      SZ_WORD: bad_access = (a != 2'b00);
      default: bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Grant decision between fetch and data requesters.
// Ports: Clk, Reset, if_req, d_req, grant (IDLE strobe) -> grant_if, grant_d.
module mem_req_arbiter (
  input  logic Clk,
  input  logic Reset,
  input  logic if_req,
  input  logic d_req,
  input  logic grant,
  output logic grant_if,
  output logic grant_d
);
  import mem_seq_pkg::*;

  // consecutive data grants taken while a fetch was waiting
  logic [1:0] starve;

  assign grant_d  = grant && d_req &&
                    !(starve == 2'd2 && if_req);
  assign grant_if = grant && if_req && !grant_d;

  always_ff @(posedge Clk) begin
    if (Reset)
      starve <= 2'd0;
    else if (grant_if)
      starve <= 2'd0;
    else if (grant_d)
      starve <= if_req ? starve + 2'd1 : 2'd0;
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Shares a byte-wide RAM between fetch and load/store, splitting
// accesses into big-endian byte ops with alignment and timeout errors.
module mem_access_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              err,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_moc
);
  import mem_seq_pkg::*;

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

  state_t state, nxt;

  logic [ADDR_W-1:0] base;
  logic [1:0]        size;
  logic [1:0]        idx;
  logic              we;
  logic              own_if;
  logic [31:0]       wdata;
  logic [31:0]       asm_q;
  logic [31:0]       asm_d;
  logic [WCW-1:0]    wcnt;

  logic              grant_if;
  logic              grant_d;
  logic              granted;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [1:0]        lane;
  logic              last;

  mem_req_arbiter u_arb (
    .Clk      (Clk),
    .Reset    (Reset),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant    (state == IDLE),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign granted  = grant_if | grant_d;
  assign req_addr = grant_if ? if_addr : d_addr;
  assign req_size = grant_if ? SZ_WORD : d_size;

  // big-endian: byte index 0 maps to the most significant lane
  assign lane = last_idx(size) - idx;
  assign last = (idx == last_idx(size));

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    ram_en    = 1'b0;
    ram_rw    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 8'h00;
    if_done   = 1'b0;
    d_done    = 1'b0;
    err       = 1'b0;
    asm_d     = asm_q;
    asm_d[{lane, 3'b000} +: 8] = ram_rdata;
    unique case (state)
      IDLE: begin
        if (granted)
          nxt = bad_access(req_size, req_addr[1:0])
                ? ERR : ISSUE;
      end
      ISSUE: begin
        ram_rw    = we ? RW_WRITE : RW_READ;
        ram_addr  = base + ADDR_W'(idx);
        ram_wdata = wdata[{lane, 3'b000} +: 8];
        nxt       = WAIT;
      end
      WAIT: begin
        ram_en    = 1'b1;
        ram_rw    = we ? RW_WRITE : RW_READ;
        ram_addr  = base + ADDR_W'(idx);
        ram_wdata = wdata[{lane, 3'b000} +: 8];
        if (ram_moc)
          nxt = last ? DONE : ISSUE;
        else if (wcnt == WLAST)
          nxt = ERR;
      end
      DONE: begin
        if_done = own_if;
        d_done  = !own_if;
        nxt     = IDLE;
      end
      ERR: begin
        if_done = own_if;
        d_done  = !own_if;
        err     = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      base     <= '0;
      size     <= 2'b00;
      idx      <= 2'd0;
      we       <= 1'b0;
      own_if   <= 1'b0;
      wdata    <= 32'h0;
      asm_q    <= 32'h0;
      wcnt     <= '0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
    end else begin
      if (state == IDLE && granted) begin
        base   <= req_addr;
        size   <= req_size;
        we     <= grant_if ? 1'b0 : d_we;
        wdata  <= d_wdata;
        own_if <= grant_if;
        idx    <= 2'd0;
        wcnt   <= '0;
        asm_q  <= 32'h0;
      end
      if (state == WAIT) begin
        if (ram_moc) begin
          wcnt <= '0;
          idx  <= idx + 2'd1;
          if (!we)
            asm_q <= asm_d;
          // load the result on entry to DONE so it is
          // already valid while the done pulse is high
          if (last && !we) begin
            if (own_if)
              if_rdata <= asm_d;
            else
              d_rdata <= asm_d;
          end
        end else begin
          wcnt <= wcnt + WCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer with a byte RAM model.
// Driver pushes expected done responses; a monitor pops and compares.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = 8'h0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [7:0]  d_addr = 8'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        ram_en;
  logic        ram_rw;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_moc;

  mem_access_sequencer #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .err       (err),
    .ram_en    (ram_en),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_moc   (ram_moc)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int en_total = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // RAM model: moc after moc_delay WAIT cycles (-1 = never)
  logic [7:0] mem [256];
  int         moc_delay = 0;
  int         en_cnt = 0;
  logic [7:0] addr_log[$];

  assign ram_rdata = mem[ram_addr];
  assign ram_moc = ram_en && moc_delay >= 0 &&
                   en_cnt == moc_delay;

  always @(posedge Clk) begin
    if (ram_en && ram_moc) begin
      addr_log.push_back(ram_addr);
      if (ram_rw == RW_WRITE)
        mem[ram_addr] <= ram_wdata;
    end
    if (ram_en && !ram_moc)
      en_cnt <= en_cnt + 1;
    else
      en_cnt <= 0;
  end

  always @(negedge Clk)
    if (!Reset && ram_en) en_total++;

  typedef struct {
    bit          is_if;
    bit          err;
    logic [31:0] rdata;
    int          c0;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // monitor
  always @(negedge Clk) begin
    if (!Reset && (d_done || if_done)) begin
      exp_t e;
      logic [31:0] rd;
      int lat;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL done_unexp: if_done=%0b d_done=%0b, none expected",
                 if_done, d_done);
      end else begin
        e = sb.pop_front();
        rd = if_done ? if_rdata : d_rdata;
        lat = cyc - e.c0;
        if (if_done != e.is_if || (if_done && d_done) ||
            err != e.err || rd !== e.rdata ||
            (e.lat >= 0 && lat != e.lat))
          $display({"FAIL done_resp: got if=%0b d=%0b err=%0b ",
                    "rd=%h lat=%0d, exp if=%0b err=%0b rd=%h lat=%0d"},
                   if_done, d_done, err, rd, lat,
                   e.is_if, e.err, e.rdata, e.lat);
        else
          passes++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h exp %h", nm, got, exp);
  endtask

  task automatic wait_done(input bit is_if);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!(is_if ? if_done : d_done) && n < 200);
    if (n >= 200) begin
      checks++;
      $display("FAIL timeout: no done after %0d cycles, exp 1", n);
    end
  endtask

  logic [31:0] m_drd = 32'h0;
  logic [31:0] m_ird = 32'h0;

  task automatic run_d(input bit we, input logic [1:0] sz,
                       input logic [7:0] a, input logic [31:0] wd,
                       input bit e_err, input logic [31:0] e_rd,
                       input int e_lat);
    exp_t x;
    @(posedge Clk); #1;
    d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    x = '{1'b0, e_err, e_rd, cyc, e_lat};
    sb.push_back(x);
    wait_done(1'b0);
    @(posedge Clk); #1;
    d_req = 1'b0;
  endtask

  task automatic run_if(input logic [7:0] a, input bit e_err,
                        input logic [31:0] e_rd, input int e_lat);
    exp_t x;
    @(posedge Clk); #1;
    if_addr = a;
    if_req = 1'b1;
    x = '{1'b1, e_err, e_rd, cyc, e_lat};
    sb.push_back(x);
    wait_done(1'b1);
    @(posedge Clk); #1;
    if_req = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    return {14'h0, if_done, d_done, err, ram_en, ram_rw,
            ram_addr, ram_wdata, 1'b0} ^
           {if_rdata, d_rdata};
  endfunction

  initial begin
    int e0;
    exp_t x;
    int n;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB;
    mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    mem[8'h05] = 8'h80;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outs", outs(), 64'h0);
    chk("reset_if_rdata", {32'h0, if_rdata}, 64'h0);
    Reset = 1'b0;

    // 1: word load at 0x10
    addr_log.delete();
    m_drd = 32'hAABBCCDD;
    run_d(1'b0, SZ_WORD, 8'h10, 32'h0, 1'b0, m_drd, 9);
    chk("t1_nbytes", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4)
      chk("t1_addrs",
          {32'h0, addr_log[0], addr_log[1], addr_log[2], addr_log[3]},
          64'h10111213);

    // 2: misaligned halfword store, then aligned
    e0 = en_total;
    run_d(1'b1, SZ_HALF, 8'h21, 32'h1234, 1'b1, m_drd, 1);
    chk("t2_no_ram_en", 64'(en_total - e0), 64'd0);
    run_d(1'b1, SZ_HALF, 8'h22, 32'h1234, 1'b0, m_drd, 5);
    chk("t2_mem22", {56'h0, mem[8'h22]}, 64'h12);
    chk("t2_mem23", {56'h0, mem[8'h23]}, 64'h34);

    // 6: byte load with moc delayed 3 cycles
    moc_delay = 3;
    m_drd = 32'h00000080;
    run_d(1'b0, SZ_BYTE, 8'h05, 32'h0, 1'b0, m_drd, 6);

    // 3: both requesters held high
    moc_delay = 0;
    m_ird = 32'hAABBCCDD;
    @(posedge Clk); #1;
    d_we = 1'b0; d_size = SZ_BYTE; d_addr = 8'h05;
    if_addr = 8'h10;
    d_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = '{(i % 3) == 2, 1'b0,
            ((i % 3) == 2) ? m_ird : m_drd, 0, -1};
      sb.push_back(x);
    end
    n = 0; k = 0;
    while (n < 6 && k < 300) begin
      @(negedge Clk);
      k++;
      if (d_done || if_done) n++;
    end
    chk("t3_ndone", 64'(n), 64'd6);
    @(posedge Clk); #1;
    d_req = 1'b0; if_req = 1'b0;

    // 4: byte load, RAM never completes
    moc_delay = -1;
    e0 = en_total;
    run_d(1'b0, SZ_BYTE, 8'h07, 32'h0, 1'b1, m_drd, 17);
    chk("t4_en_cycles", 64'(en_total - e0), 64'd15);
    moc_delay = 0;

    // 5: reset during byte 2 of a fetch
    @(posedge Clk); #1;
    if_addr = 8'h10;
    if_req = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b1;
    if_req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("t5_reset_outs", outs(), 64'h0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    Reset = 1'b0;
    m_drd = 32'h0;
    run_if(8'h10, 1'b0, 32'hAABBCCDD, 9);

    repeat (3) @(posedge Clk);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
